// File: rtl/wb_ctrl_pipe.sv
// Writeback-control pipeline: decodes the D-stage instruction once, then
// carries dest reg, write enable, Mem2Reg and a self-decrementing Tnew down
// DEPTH plain flop stages (E, M, W, ...) for writeback and hazard detection.

// One pipeline stage register. DEC selects whether Tnew counts down on entry
// (every stage except E, which loads the freshly decoded value).
module wb_ctrl_stage #(
    parameter int TW  = 2,
    parameter bit DEC = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    a3_in,
    input  logic [TW-1:0] tnew_in,
    input  logic          we_in,
    input  logic [1:0]    m2r_in,
    input  logic          mvz_in,
    output logic [4:0]    a3_q,
    output logic [TW-1:0] tnew_q,
    output logic          we_q,
    output logic [1:0]    m2r_q,
    output logic          mvz_q
);

    logic [TW-1:0] tnew_nxt;

    // Saturating countdown of cycles until the result becomes available
    always_comb begin
        tnew_nxt = tnew_in;
        if (DEC && (tnew_in != '0))
            tnew_nxt = tnew_in - TW'(1);
    end

    // Stage flops; reset clears every field
    always_ff @(posedge clk) begin
        if (reset) begin
            a3_q   <= '0;
            tnew_q <= '0;
            we_q   <= 1'b0;
            m2r_q  <= 2'b00;
            mvz_q  <= 1'b0;
        end else begin
            a3_q   <= a3_in;
            tnew_q <= tnew_nxt;
            we_q   <= we_in;
            m2r_q  <= m2r_in;
            mvz_q  <= mvz_in;
        end
    end

endmodule

module wb_ctrl_pipe #(
    parameter int DEPTH     = 3,
    parameter int ALU_TNEW  = 1,
    parameter int LOAD_TNEW = 2,
    parameter int TW        = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr_d,
    input  logic                stall,
    input  logic                flush,
    input  logic                movz_cancel_e,
    output logic [5*DEPTH-1:0]  a3_bus,
    output logic [TW*DEPTH-1:0] tnew_bus,
    output logic [DEPTH-1:0]    we_bus,
    output logic [1:0]          mem2reg_w,
    output logic [4:0]          a3_w,
    output logic                we_w
);

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC8 = 2'b10;

    logic [5:0] op, func;
    logic [4:0] rt, rd;

    logic          dec_wr, dec_mvz, dec_we;
    logic [4:0]    dec_dst;
    logic [1:0]    dec_m2r;
    logic [TW-1:0] dec_tn;

    logic [DEPTH-1:0][4:0]    a3_in,   a3_q;
    logic [DEPTH-1:0][TW-1:0] tnew_in, tnew_q;
    logic [DEPTH-1:0]         we_in,   we_q;
    logic [DEPTH-1:0][1:0]    m2r_in,  m2r_q;
    logic [DEPTH-1:0]         mvz_in,  mvz_q;

    logic unused_bits;

    assign op   = instr_d[31:26];
    assign rt   = instr_d[20:16];
    assign rd   = instr_d[15:11];
    assign func = instr_d[5:0];

    // rs and shamt never affect writeback control; only E's movz flag is consumed
    assign unused_bits = ^{instr_d[25:21], instr_d[10:6], mvz_q[DEPTH-1:1]};

    // D decode; non-writers and writes to $0 collapse to an all-zero bubble
    always_comb begin
        dec_wr  = 1'b0;
        dec_mvz = 1'b0;
        dec_dst = 5'd0;
        dec_m2r = M2R_ALU;
        dec_tn  = '0;
        case (op)
            6'h00: begin
                case (func)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        dec_wr  = 1'b1;
                        dec_dst = rd;
                        dec_tn  = TW'(ALU_TNEW);
                    end
                    6'h0a: begin
                        dec_wr  = 1'b1;
                        dec_mvz = 1'b1;
                        dec_dst = rd;
                        dec_tn  = TW'(ALU_TNEW);
                    end
                    6'h09: begin
                        dec_wr  = 1'b1;
                        dec_dst = rd;
                        dec_m2r = M2R_PC8;
                    end
                    default: ;
                endcase
            end
            6'h03: begin
                dec_wr  = 1'b1;
                dec_dst = 5'd31;
                dec_m2r = M2R_PC8;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                dec_wr  = 1'b1;
                dec_dst = rt;
                dec_tn  = TW'(ALU_TNEW);
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec_wr  = 1'b1;
                dec_dst = rt;
                dec_m2r = M2R_MEM;
                dec_tn  = TW'(LOAD_TNEW);
            end
            default: ;
        endcase
        dec_we = dec_wr && (dec_dst != 5'd0);
        if (!dec_we) begin
            dec_mvz = 1'b0;
            dec_dst = 5'd0;
            dec_m2r = M2R_ALU;
            dec_tn  = '0;
        end
    end

    // Stage inputs: bubble or decode into E, plain shift behind it, movz cancel on E->M
    always_comb begin
        a3_in   = '0;
        tnew_in = '0;
        we_in   = '0;
        m2r_in  = '0;
        mvz_in  = '0;
        if (!(stall || flush)) begin
            a3_in[0]   = dec_dst;
            tnew_in[0] = dec_tn;
            we_in[0]   = dec_we;
            m2r_in[0]  = dec_m2r;
            mvz_in[0]  = dec_mvz;
        end
        for (int i = 1; i < DEPTH; i++) begin
            a3_in[i]   = a3_q[i-1];
            tnew_in[i] = tnew_q[i-1];
            we_in[i]   = we_q[i-1];
            m2r_in[i]  = m2r_q[i-1];
            mvz_in[i]  = mvz_q[i-1];
        end
        if (movz_cancel_e && mvz_q[0]) begin
            a3_in[1] = 5'd0;
            we_in[1] = 1'b0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stg
        wb_ctrl_stage #(
            .TW  (TW),
            .DEC (g != 0)
        ) u_stg (
            .clk     (clk),
            .reset   (reset),
            .a3_in   (a3_in[g]),
            .tnew_in (tnew_in[g]),
            .we_in   (we_in[g]),
            .m2r_in  (m2r_in[g]),
            .mvz_in  (mvz_in[g]),
            .a3_q    (a3_q[g]),
            .tnew_q  (tnew_q[g]),
            .we_q    (we_q[g]),
            .m2r_q   (m2r_q[g]),
            .mvz_q   (mvz_q[g])
        );
    end

    assign a3_bus    = a3_q;
    assign tnew_bus  = tnew_q;
    assign we_bus    = we_q;
    assign mem2reg_w = m2r_q[DEPTH-1];
    assign a3_w      = a3_q[DEPTH-1];
    assign we_w      = we_q[DEPTH-1];

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Scoreboard bench for wb_ctrl_pipe: a default (DEPTH=3) and a deep
// (DEPTH=5, LOAD_TNEW=3) instance share one stimulus stream. A reference model
// tracks each in-flight instruction by age; a monitor compares every cycle.
module tb_wb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_d = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        movz_cancel_e = 1'b0;

    logic [14:0] a3_bus_a;
    logic [5:0]  tnew_bus_a;
    logic [2:0]  we_bus_a;
    logic [1:0]  m2r_w_a;
    logic [4:0]  a3_w_a;
    logic        we_w_a;

    logic [24:0] a3_bus_b;
    logic [9:0]  tnew_bus_b;
    logic [4:0]  we_bus_b;
    logic [1:0]  m2r_w_b;
    logic [4:0]  a3_w_b;
    logic        we_w_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ctrl_pipe u_dut_a (
        .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall), .flush(flush),
        .movz_cancel_e(movz_cancel_e), .a3_bus(a3_bus_a), .tnew_bus(tnew_bus_a),
        .we_bus(we_bus_a), .mem2reg_w(m2r_w_a), .a3_w(a3_w_a), .we_w(we_w_a)
    );

    wb_ctrl_pipe #(.DEPTH(5), .ALU_TNEW(1), .LOAD_TNEW(3), .TW(2)) u_dut_b (
        .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall), .flush(flush),
        .movz_cancel_e(movz_cancel_e), .a3_bus(a3_bus_b), .tnew_bus(tnew_bus_b),
        .we_bus(we_bus_b), .mem2reg_w(m2r_w_b), .a3_w(a3_w_b), .we_w(we_w_b)
    );

    // One in-flight instruction as seen by the writeback logic; tnew is the D value
    typedef struct packed {
        logic [4:0] dest;
        logic       we;
        logic [1:0] m2r;
        logic [3:0] tnew;
        logic       movz;
    } rec_t;

    typedef struct packed {
        logic [29:0] a3;
        logic [11:0] tnew;
        logic [5:0]  we;
        logic [1:0]  m2r;
        logic [4:0]  a3w;
        logic        wew;
    } exp_t;

    rec_t hist [2][6];
    int   dep  [2] = '{3, 5};
    int   ldt  [2] = '{2, 3};
    exp_t qa[$];
    exp_t qb[$];

    function automatic rec_t decode(logic [31:0] in, int load_t);
        rec_t r;
        logic [5:0] o, f;
        o = in[31:26];
        f = in[5:0];
        r = '0;
        if (o == 6'h00) begin
            if (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b})
                r = '{dest: in[15:11], we: 1'b1, m2r: 2'b00, tnew: 4'd1, movz: 1'b0};
            else if (f == 6'h0a)
                r = '{dest: in[15:11], we: 1'b1, m2r: 2'b00, tnew: 4'd1, movz: 1'b1};
            else if (f == 6'h09)
                r = '{dest: in[15:11], we: 1'b1, m2r: 2'b10, tnew: 4'd0, movz: 1'b0};
        end else if (o == 6'h03) begin
            r = '{dest: 5'd31, we: 1'b1, m2r: 2'b10, tnew: 4'd0, movz: 1'b0};
        end else if (o >= 6'h08 && o <= 6'h0f) begin
            r = '{dest: in[20:16], we: 1'b1, m2r: 2'b00, tnew: 4'd1, movz: 1'b0};
        end else if (o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
            r = '{dest: in[20:16], we: 1'b1, m2r: 2'b01, tnew: 4'(load_t), movz: 1'b0};
        end
        if (r.dest == 5'd0) r = '0;
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge
    function automatic void step();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int i = 0; i < 6; i++) hist[m][i] = '0;
            end else begin
                for (int i = dep[m] - 1; i >= 1; i--) begin
                    hist[m][i] = hist[m][i-1];
                    if (i == 1 && movz_cancel_e && hist[m][0].movz) begin
                        hist[m][1].we   = 1'b0;
                        hist[m][1].dest = 5'd0;
                    end
                end
                hist[m][0] = (stall || flush) ? rec_t'('0) : decode(instr_d, ldt[m]);
            end
        end
    endfunction

    function automatic exp_t expect_of(int m);
        exp_t e;
        int   t;
        e = '0;
        for (int i = 0; i < dep[m]; i++) begin
            e.a3[5*i +: 5] = hist[m][i].dest;
            e.we[i]        = hist[m][i].we;
            t = int'(hist[m][i].tnew) - i;
            if (t < 0) t = 0;
            e.tnew[2*i +: 2] = 2'(t);
        end
        e.m2r = hist[m][dep[m]-1].m2r;
        e.a3w = hist[m][dep[m]-1].dest;
        e.wew = hist[m][dep[m]-1].we;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; expected post-edge outputs go to the scoreboard
    task automatic cyc(input logic [31:0] in, input logic s, input logic f,
                       input logic c, input logic r);
        instr_d       = in;
        stall         = s;
        flush         = f;
        movz_cancel_e = c;
        reset         = r;
        @(posedge clk);
        step();
        qa.push_back(expect_of(0));
        qb.push_back(expect_of(1));
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] o, f;
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        f  = 6'h21;
        o  = 6'h00;
        if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 11))
                0: f = 6'h21;  1: f = 6'h23;  2: f = 6'h25;  3: f = 6'h2a;
                4: f = 6'h00;  5: f = 6'h02;  6: f = 6'h0a;  7: f = 6'h0a;
                8: f = 6'h09;  9: f = 6'h08; 10: f = 6'h18; default: f = 6'h27;
            endcase
        end else begin
            case ($urandom_range(0, 12))
                0: o = 6'h09;  1: o = 6'h0d;  2: o = 6'h0f;  3: o = 6'h23;
                4: o = 6'h20;  5: o = 6'h24;  6: o = 6'h21;  7: o = 6'h25;
                8: o = 6'h2b;  9: o = 6'h04; 10: o = 6'h02; 11: o = 6'h03;
                default: o = 6'h3f;
            endcase
            f = 6'($urandom_range(0, 63));
        end
        return {o, rs, rt, rd, 5'($urandom_range(0, 31)), f};
    endfunction

    // Monitor: compare the DUT state after each edge against the queued expectation
    initial begin
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_a3_bus",   32'(a3_bus_a),   32'(ea.a3[14:0]));
                chk("a_tnew_bus", 32'(tnew_bus_a), 32'(ea.tnew[5:0]));
                chk("a_we_bus",   32'(we_bus_a),   32'(ea.we[2:0]));
                chk("a_mem2reg_w",32'(m2r_w_a),    32'(ea.m2r));
                chk("a_a3_w",     32'(a3_w_a),     32'(ea.a3w));
                chk("a_we_w",     32'(we_w_a),     32'(ea.wew));
                chk("b_a3_bus",   32'(a3_bus_b),   32'(eb.a3[24:0]));
                chk("b_tnew_bus", 32'(tnew_bus_b), 32'(eb.tnew[9:0]));
                chk("b_we_bus",   32'(we_bus_b),   32'(eb.we[4:0]));
                chk("b_mem2reg_w",32'(m2r_w_b),    32'(eb.m2r));
                chk("b_a3_w",     32'(a3_w_b),     32'(eb.a3w));
                chk("b_we_w",     32'(we_w_b),     32'(eb.wew));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] ADDU  = 32'h00221821;
    localparam logic [31:0] LW5   = 32'h8C050000;
    localparam logic [31:0] JAL   = 32'h0C000010;
    localparam logic [31:0] ADDI0 = 32'h24000005;
    localparam logic [31:0] MOVZ4 = 32'h0022200A;
    localparam logic [31:0] NOP   = 32'h00000000;

    initial begin
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 6; i++) hist[m][i] = '0;

        // reset, then the basic writeback classes
        cyc(NOP, 0, 0, 0, 1);
        cyc(ADDU, 0, 0, 0, 0);
        cyc(LW5, 0, 0, 0, 0);
        cyc(JAL, 0, 0, 0, 0);
        cyc(ADDI0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(NOP, 0, 0, 0, 0);
        // load ahead of a two-cycle stall, then stall+flush together
        cyc(LW5, 0, 0, 0, 0);
        cyc(ADDU, 1, 0, 0, 0);
        cyc(ADDU, 1, 0, 0, 0);
        cyc(ADDU, 0, 0, 0, 0);
        cyc(ADDU, 1, 1, 0, 0);
        cyc(ADDU, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(NOP, 0, 0, 0, 0);
        // movz cancelled, then kept; cancel on a non-movz is ignored
        cyc(MOVZ4, 0, 0, 0, 0);
        cyc(ADDU, 0, 0, 1, 0);
        cyc(MOVZ4, 0, 0, 1, 0);
        cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(NOP, 0, 0, 0, 0);
        // reset with three in flight, overriding stall/flush/cancel
        cyc(ADDU, 0, 0, 0, 0);
        cyc(LW5, 0, 0, 0, 0);
        cyc(MOVZ4, 0, 0, 0, 0);
        cyc(JAL, 1, 1, 1, 1);
        // deep-instance load walk from a clean pipe
        cyc(LW5, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(NOP, 0, 0, 0, 0);

        for (int n = 0; n < 1500; n++)
            cyc(rnd_instr(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
